// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell, LSB first,
// WIDTH shift cycles per operation behind a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;

    logic             cur_bit;
    logic             bor_next;
    logic [WIDTH-1:0] sr_ext;

    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        sr_d         = sr_q;
        bor_d        = bor_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;

        cur_bit  = sa_q[0] ^ sb_q[0] ^ bor_q;
        bor_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bor_q);
        // Result bits enter at the top; after the last bit the whole word is aligned.
        sr_ext   = {cur_bit, sr_q};

        case (state_q)
            S_SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_ext[WIDTH-1:1];
                bor_d = bor_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // sa_q[0]/sb_q[0] now hold the operand sign bits.
                    state_d      = S_DONE;
                    diff_d       = sr_ext;
                    borrow_out_d = bor_next;
                    overflow_d   = (sa_q[0] ^ sb_q[0]) & (cur_bit ^ sa_q[0]);
                    cnt_d        = '0;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_SHIFT;
                    sa_d    = a;
                    sb_d    = b;
                    sr_d    = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            sr_q         <= '0;
            bor_q        <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            sr_q         <= sr_d;
            bor_q        <= bor_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for handshake/latency
// cases and a 4-bit instance swept over every operand pair.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bor8, ovf8;
    logic [7:0] diff8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bor4, ovf4;
    logic [3:0] diff4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(bor8), .overflow(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4),
        .borrow_out(bor4), .overflow(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Starts one 8-bit op and returns edges from the accept edge to done, plus busy cycles seen.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v,
                       output int lat, output int busy_cnt);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = ta; b8 = tb_v;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~ta; b8 = ~tb_v;
        lat = 0; busy_cnt = 0;
        while (!done8 && lat < 30) begin
            if (busy8) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, n;
        logic [3:0] ea, eb, ed, prev4;
        logic       eo;

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        #12;
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_diff", diff8, 8'h00);
        chk("rst_bor", bor8, 1'b0);
        chk("rst_ovf", ovf8, 1'b0);
        @(negedge clk); rst = 1'b0;

        op8(8'd100, 8'd37, lat, bc);
        chk("basic_lat", lat, 8);
        chk("basic_busy_cycles", bc, 8);
        chk("basic_diff", diff8, 8'd63);
        chk("basic_bor", bor8, 1'b0);
        chk("basic_ovf", ovf8, 1'b0);
        @(posedge clk); #1;
        chk("done_single_pulse", done8, 1'b0);
        chk("idle_after_done", busy8, 1'b0);

        op8(8'h05, 8'h0A, lat, bc);
        chk("wrap_diff", diff8, 8'hFB);
        chk("wrap_bor", bor8, 1'b1);
        chk("wrap_ovf", ovf8, 1'b0);
        op8(8'h00, 8'h01, lat, bc);
        chk("zero_minus_one_diff", diff8, 8'hFF);
        chk("zero_minus_one_bor", bor8, 1'b1);

        op8(8'h80, 8'h01, lat, bc);
        chk("ovf1_diff", diff8, 8'h7F);
        chk("ovf1_ovf", ovf8, 1'b1);
        chk("ovf1_bor", bor8, 1'b0);
        op8(8'h7F, 8'hFF, lat, bc);
        chk("ovf2_diff", diff8, 8'h80);
        chk("ovf2_ovf", ovf8, 1'b1);
        chk("ovf2_bor", bor8, 1'b1);

        // Reset three bits into an op; outputs currently hold a nonzero result.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd37;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_busy", busy8, 1'b0);
        chk("midrst_done", done8, 1'b0);
        chk("midrst_diff", diff8, 8'h00);
        chk("midrst_bor", bor8, 1'b0);
        chk("midrst_ovf", ovf8, 1'b0);
        @(negedge clk); rst = 1'b0;
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy8 || done8) n++;
        end
        chk("idle_after_rst", n, 0);

        // Start pulsed again while busy must be ignored.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd37;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("ignored_busy", busy8, 1'b1);
        lat = 3;
        while (!done8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignored_lat", lat, 8);
        chk("ignored_diff", diff8, 8'd63);
        chk("ignored_bor", bor8, 1'b0);

        // Start held through DONE: back-to-back ops.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h0A;
        @(posedge clk); #1;
        a8 = 8'h80; b8 = 8'h01;
        lat = 0;
        while (!done8 && lat < 30) begin
            chk("b2b_hold_prev", diff8, 8'd63);
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_first_lat", lat, 8);
        chk("b2b_first_diff", diff8, 8'hFB);
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 1;
        chk("b2b_reaccept_busy", busy8, 1'b1);
        while (!done8 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_second_gap", n, 9);
        chk("b2b_second_diff", diff8, 8'h7F);
        chk("b2b_second_ovf", ovf8, 1'b1);
        chk("b2b_second_bor", bor8, 1'b0);

        // Every 4-bit operand pair against the arithmetic definition.
        prev4 = 4'h0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ea = i[3:0];
                eb = j[3:0];
                @(posedge clk); #1;
                start4 = 1'b1; a4 = ea; b4 = eb;
                @(posedge clk); #1;
                start4 = 1'b0;
                a4 = 4'($urandom_range(0, 15));
                b4 = 4'($urandom_range(0, 15));
                n = 0;
                while (!done4 && n < 20) begin
                    chk("w4_stable", diff4, prev4);
                    @(posedge clk); #1;
                    n++;
                end
                ed = ea - eb;
                eo = (ea[3] != eb[3]) && (ed[3] != ea[3]);
                chk("w4_lat", n, 4);
                chk("w4_diff", diff4, ed);
                chk("w4_bor", bor4, (ea < eb));
                chk("w4_ovf", ovf4, eo);
                prev4 = ed;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
